fetch_stall_ctrl: RTL and testbench

- Consumer side of the load-use hazard signal in the 5-stage MIPS pipeline.
- Owns the PC register and the IF/ID pipeline register, and sequences fetch start-up.
- Applies stall (freeze PC and IF/ID, drive a bubble into ID/EX) and branch flush (redirect PC, squash IF/ID).
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/fetch_stall_ctrl.sv | 83 ++++++++
 tb/tb_fetch_stall_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl: PC / IF-ID register owner applying load-use stalls and branch flushes.
module fetch_stall_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             hazard_i,
    input  logic             flush_i,
    input  logic [31:0]      target_i,
    input  logic [31:0]      inst_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      IF_ID_pc_o,
    output logic [31:0]      IF_ID_inst_o,
    output logic             IF_ID_valid_o,
    output logic             bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d, if_pc_q, if_pc_d, if_inst_q, if_inst_d;
    logic               if_valid_q, if_valid_d, stall_eff;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // A hazard against a squashed nop has nothing to wait for, so it never stalls.
    assign stall_eff = (state_q == RUN) && hazard_i && if_valid_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        if_valid_d  = if_valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == IDLE) begin
            state_d = start_i ? RUN : IDLE;
        end else if (stall_eff) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, ~&stall_cnt_q};
        end else if (flush_i) begin
            pc_d        = target_i;
            if_pc_d     = 32'h0;
            if_inst_d   = 32'h0;
            if_valid_d  = 1'b0;
            flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, ~&flush_cnt_q};
        end else begin
            pc_d       = pc_q + 32'd4;
            if_pc_d    = pc_q + 32'd4;
            if_inst_d  = inst_i;
            if_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            if_pc_q     <= 32'h0;
            if_inst_q   <= 32'h0;
            if_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
            if_valid_q  <= if_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_o          = pc_q;
    assign IF_ID_pc_o    = if_pc_q;
    assign IF_ID_inst_o  = if_inst_q;
    assign IF_ID_valid_o = if_valid_q;
    assign bubble_o      = stall_eff;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb_fetch_stall_ctrl: directed scenarios plus random traffic against a behavioural fetch model.
module tb_fetch_stall_ctrl;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk_i = 0, rst_i = 0, start_i = 0, hazard_i = 0, flush_i = 0;
    logic [31:0]   target_i = 0, inst_i = 0;
    logic [31:0]   pc_o, IF_ID_pc_o, IF_ID_inst_o;
    logic          IF_ID_valid_o, bubble_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    int checks = 0, failures = 0;

    bit          m_run, m_valid;
    logic [31:0] m_pc, m_ifpc, m_inst;
    int          m_sc, m_fc;

    fetch_stall_ctrl #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hazard_i(hazard_i),
        .flush_i(flush_i), .target_i(target_i), .inst_i(inst_i), .pc_o(pc_o),
        .IF_ID_pc_o(IF_ID_pc_o), .IF_ID_inst_o(IF_ID_inst_o),
        .IF_ID_valid_o(IF_ID_valid_o), .bubble_o(bubble_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic m_reset();
        m_run = 0; m_valid = 0; m_pc = 0; m_ifpc = 0; m_inst = 0; m_sc = 0; m_fc = 0;
    endtask

    // Advances one rising edge and moves the model by the fetch rules, using pre-edge inputs.
    task automatic tick();
        bit n_run = m_run, n_valid = m_valid;
        logic [31:0] n_pc = m_pc, n_ifpc = m_ifpc, n_inst = m_inst;
        int n_sc = m_sc, n_fc = m_fc;
        if (!m_run) n_run = start_i;
        else if (hazard_i && m_valid) n_sc = (m_sc == CMAX) ? CMAX : m_sc + 1;
        else if (flush_i) begin
            n_pc = target_i; n_ifpc = 0; n_inst = 0; n_valid = 0;
            n_fc = (m_fc == CMAX) ? CMAX : m_fc + 1;
        end else begin
            n_pc = m_pc + 4; n_ifpc = m_pc + 4; n_inst = inst_i; n_valid = 1;
        end
        @(posedge clk_i);
        m_run = n_run; m_valid = n_valid; m_pc = n_pc; m_ifpc = n_ifpc;
        m_inst = n_inst; m_sc = n_sc; m_fc = n_fc;
        #1;
    endtask

    task automatic do_reset();
        start_i = 0; hazard_i = 0; flush_i = 0;
        #2 rst_i = 1;
        #2 m_reset();
        rst_i = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
        checks++; if (IF_ID_valid_o !== 1'b0 || IF_ID_inst_o !== 0 || IF_ID_pc_o !== 0) begin
            failures++; $display("FAIL reset_ifid got v=%b i=%h p=%h exp 0/0/0", IF_ID_valid_o, IF_ID_inst_o, IF_ID_pc_o); end
        checks++; if (stall_cnt_o !== 0 || flush_cnt_o !== 0) begin
            failures++; $display("FAIL reset_cnt got s=%0d f=%0d exp 0/0", stall_cnt_o, flush_cnt_o); end
        hazard_i = 1; flush_i = 1; target_i = 32'h80; #1;
        checks++; if (bubble_o !== 1'b0) begin failures++; $display("FAIL idle_bubble got=%b exp=0", bubble_o); end
        tick();
        checks++; if (pc_o !== 32'h0 || flush_cnt_o !== 0) begin
            failures++; $display("FAIL idle_ignore got pc=%h fc=%0d exp 0/0", pc_o, flush_cnt_o); end
        hazard_i = 0; flush_i = 0;
    endtask

    task automatic test_start();
        inst_i = 32'h8C01_0000; start_i = 1; tick(); start_i = 0;
        checks++; if (pc_o !== 32'h0 || IF_ID_valid_o !== 1'b0) begin
            failures++; $display("FAIL start_edge got pc=%h v=%b exp 0/0", pc_o, IF_ID_valid_o); end
        tick();
        checks++; if (IF_ID_inst_o !== 32'h8C01_0000 || IF_ID_pc_o !== 4 || pc_o !== 4 || IF_ID_valid_o !== 1'b1) begin
            failures++; $display("FAIL first_fetch got i=%h p=%h pc=%h v=%b exp 8c010000/4/4/1", IF_ID_inst_o, IF_ID_pc_o, pc_o, IF_ID_valid_o); end
        inst_i = 32'h0022_1820; tick();
        checks++; if (pc_o !== 8 || IF_ID_inst_o !== 32'h0022_1820) begin
            failures++; $display("FAIL second_fetch got pc=%h i=%h exp 8/00221820", pc_o, IF_ID_inst_o); end
    endtask

    task automatic test_stall();
        hazard_i = 1; inst_i = 32'hAAAA_5555; #1;
        checks++; if (bubble_o !== 1'b1) begin failures++; $display("FAIL stall_bubble got=%b exp=1", bubble_o); end
        tick();
        checks++; if (pc_o !== 8 || IF_ID_pc_o !== 8 || IF_ID_inst_o !== 32'h0022_1820 || stall_cnt_o !== 1) begin
            failures++; $display("FAIL stall_hold got pc=%h p=%h i=%h sc=%0d exp 8/8/00221820/1", pc_o, IF_ID_pc_o, IF_ID_inst_o, stall_cnt_o); end
        hazard_i = 0; #1;
        checks++; if (bubble_o !== 1'b0) begin failures++; $display("FAIL stall_release_bubble got=%b exp=0", bubble_o); end
        tick();
        checks++; if (pc_o !== 12 || IF_ID_inst_o !== 32'hAAAA_5555) begin
            failures++; $display("FAIL stall_resume got pc=%h i=%h exp c/aaaa5555", pc_o, IF_ID_inst_o); end
    endtask

    task automatic test_flush();
        flush_i = 1; target_i = 32'h40; tick(); flush_i = 0;
        checks++; if (pc_o !== 32'h40 || IF_ID_valid_o !== 0 || IF_ID_inst_o !== 0 || IF_ID_pc_o !== 0 || flush_cnt_o !== 1) begin
            failures++; $display("FAIL flush got pc=%h v=%b i=%h p=%h fc=%0d exp 40/0/0/0/1", pc_o, IF_ID_valid_o, IF_ID_inst_o, IF_ID_pc_o, flush_cnt_o); end
        hazard_i = 1; #1;
        checks++; if (bubble_o !== 1'b0) begin failures++; $display("FAIL nop_hazard_bubble got=%b exp=0", bubble_o); end
        tick(); hazard_i = 0;
        checks++; if (pc_o !== 32'h44 || stall_cnt_o !== 1 || IF_ID_valid_o !== 1) begin
            failures++; $display("FAIL nop_hazard_nostall got pc=%h sc=%0d v=%b exp 44/1/1", pc_o, stall_cnt_o, IF_ID_valid_o); end
    endtask

    task automatic test_stall_priority();
        hazard_i = 1; flush_i = 1; target_i = 32'h100; #1;
        checks++; if (bubble_o !== 1'b1) begin failures++; $display("FAIL prio_bubble got=%b exp=1", bubble_o); end
        tick(); hazard_i = 0;
        checks++; if (pc_o !== 32'h44 || flush_cnt_o !== 1 || stall_cnt_o !== 2) begin
            failures++; $display("FAIL prio_stall got pc=%h fc=%0d sc=%0d exp 44/1/2", pc_o, flush_cnt_o, stall_cnt_o); end
        tick(); flush_i = 0;
        checks++; if (pc_o !== 32'h100 || flush_cnt_o !== 2 || IF_ID_valid_o !== 0) begin
            failures++; $display("FAIL prio_redirect got pc=%h fc=%0d v=%b exp 100/2/0", pc_o, flush_cnt_o, IF_ID_valid_o); end
    endtask

    task automatic test_saturation();
        int exp_sc[5] = '{1, 2, 3, 3, 3};
        do_reset();
        start_i = 1; tick(); start_i = 0; tick();
        hazard_i = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (stall_cnt_o !== exp_sc[i][CW-1:0] || flush_cnt_o !== 0) begin
                failures++; $display("FAIL stall_sat[%0d] got sc=%0d fc=%0d exp %0d/0", i, stall_cnt_o, flush_cnt_o, exp_sc[i]); end
        end
        #2 rst_i = 1; #1;
        checks++; if (pc_o !== 0 || IF_ID_valid_o !== 0 || IF_ID_inst_o !== 0 || IF_ID_pc_o !== 0 || stall_cnt_o !== 0 || flush_cnt_o !== 0 || bubble_o !== 0) begin
            failures++; $display("FAIL async_reset got pc=%h v=%b i=%h p=%h sc=%0d fc=%0d b=%b exp all 0", pc_o, IF_ID_valid_o, IF_ID_inst_o, IF_ID_pc_o, stall_cnt_o, flush_cnt_o, bubble_o); end
        hazard_i = 0; m_reset(); rst_i = 0; #1;
    endtask

    task automatic test_wrap();
        start_i = 1; tick(); start_i = 0; tick();
        flush_i = 1; target_i = 32'hFFFF_FFFC; tick(); flush_i = 0;
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_target got=%h exp=fffffffc", pc_o); end
        inst_i = 32'h1234_5678; tick();
        checks++; if (pc_o !== 0 || IF_ID_pc_o !== 0 || IF_ID_valid_o !== 1 || IF_ID_inst_o !== 32'h1234_5678) begin
            failures++; $display("FAIL wrap got pc=%h p=%h v=%b i=%h exp 0/0/1/12345678", pc_o, IF_ID_pc_o, IF_ID_valid_o, IF_ID_inst_o); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(59) == 0) do_reset();
            start_i  = ($urandom_range(3) == 0);
            hazard_i = ($urandom_range(2) == 0);
            flush_i  = ($urandom_range(3) == 0);
            target_i = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(7)) : $urandom;
            inst_i   = $urandom;
            #1;
            checks++; if (bubble_o !== (m_run && hazard_i && m_valid)) begin
                failures++; $display("FAIL rand_bubble[%0d] got=%b exp=%b", n, bubble_o, m_run && hazard_i && m_valid); end
            tick();
            checks++; if (pc_o !== m_pc || IF_ID_pc_o !== m_ifpc || IF_ID_inst_o !== m_inst || IF_ID_valid_o !== m_valid) begin
                failures++; $display("FAIL rand_state[%0d] got pc=%h p=%h i=%h v=%b exp %h/%h/%h/%b", n, pc_o, IF_ID_pc_o, IF_ID_inst_o, IF_ID_valid_o, m_pc, m_ifpc, m_inst, m_valid); end
            checks++; if (stall_cnt_o !== m_sc[CW-1:0] || flush_cnt_o !== m_fc[CW-1:0]) begin
                failures++; $display("FAIL rand_cnt[%0d] got sc=%0d fc=%0d exp %0d/%0d", n, stall_cnt_o, flush_cnt_o, m_sc, m_fc); end
        end
    endtask

    initial begin
        m_reset();
        #3;
        test_reset();
        test_start();
        test_stall();
        test_flush();
        test_stall_priority();
        test_saturation();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
